// File: rtl/arp_reply_tx_if.sv
// Byte-stream transmit handshake between the ARP reply builder and the PHY path.
// A byte moves when o_data_vl and i_rdy are both high on a clock edge.
interface arp_reply_tx_if;
    logic [7:0] o_data;
    logic       o_data_vl;
    logic       i_rdy;

    modport master (output o_data, output o_data_vl, input i_rdy);
    modport slave  (input o_data, input o_data_vl, output i_rdy);
endinterface

// File: rtl/arp_reply_tx.sv
// ARP responder: on a matching ARP request, streams a 72-byte reply frame
// (preamble/SFD, 60-byte body, FCS) over a ready handshake, then holds an IFG.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | waiting for a matching ARP request
// S_PREAMBLE | sending 0x55 x7 then SFD 0xD5
// S_BODY     | sending the 60-byte reply body, CRC accumulating
// S_FCS      | sending ~crc, least-significant byte first
// S_IFG      | inter-frame gap, output idle, new requests dropped
module arp_reply_tx #(
    parameter int unsigned IFG_CYCLES = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [47:0]           i_self_mac,
    input  logic [31:0]           i_self_ip,
    input  logic [1:0]            i_pkt_type,
    input  logic [47:0]           i_sha,
    input  logic [31:0]           i_spa,
    input  logic [31:0]           i_tpa,
    arp_reply_tx_if.master        tx,
    output logic                  o_busy,
    output logic                  o_sent,
    output logic                  o_dropped
);

    localparam int IFG_W = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_PREAMBLE, S_BODY, S_FCS, S_IFG} state_t;

    state_t             state;
    logic [5:0]         cnt_q;
    logic [IFG_W-1:0]   ifg_cnt;
    logic [31:0]        crc_q;
    logic [31:0]        crc_nxt;
    logic [7:0]         data_q;
    logic               vl_q;
    logic [47:0]        sha_q;
    logic [31:0]        spa_q;
    logic [47:0]        mac_q;
    logic [31:0]        ip_q;
    logic [335:0]       hdr;
    logic               trigger;
    logic               xfer;

    assign trigger = (i_pkt_type == 2'd1) && (i_tpa == i_self_ip);
    assign xfer    = vl_q && tx.i_rdy;
    assign o_busy  = (state != S_IDLE);
    assign tx.o_data    = data_q;
    assign tx.o_data_vl = vl_q;

    // First 42 body bytes, byte 0 in the top octet; bytes 42..59 are zero pad.
    assign hdr = {sha_q, mac_q, 16'h0806, 16'h0001, 16'h0800, 8'h06, 8'h04,
                  16'h0002, mac_q, ip_q, sha_q, spa_q};

    function automatic logic [7:0] body_byte(input logic [5:0] idx);
        logic [8:0] lsb;
        if (idx > 6'd41) return 8'h00;
        lsb = 9'(8 * (41 - int'(idx)));
        return hdr[lsb +: 8];
    endfunction

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    assign crc_nxt = crc_byte(crc_q, data_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt_q     <= '0;
            ifg_cnt   <= '0;
            crc_q     <= 32'hFFFF_FFFF;
            data_q    <= 8'h00;
            vl_q      <= 1'b0;
            sha_q     <= '0;
            spa_q     <= '0;
            mac_q     <= '0;
            ip_q      <= '0;
            o_sent    <= 1'b0;
            o_dropped <= 1'b0;
        end else begin
            o_sent    <= 1'b0;
            o_dropped <= 1'b0;
            if (trigger && state != S_IDLE)
                o_dropped <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (trigger) begin
                        sha_q  <= i_sha;
                        spa_q  <= i_spa;
                        mac_q  <= i_self_mac;
                        ip_q   <= i_self_ip;
                        crc_q  <= 32'hFFFF_FFFF;
                        cnt_q  <= '0;
                        data_q <= 8'h55;
                        vl_q   <= 1'b1;
                        state  <= S_PREAMBLE;
                    end
                end
                S_PREAMBLE: begin
                    if (xfer) begin
                        if (cnt_q == 6'd7) begin
                            cnt_q  <= '0;
                            data_q <= body_byte(6'd0);
                            state  <= S_BODY;
                        end else begin
                            cnt_q  <= cnt_q + 6'd1;
                            data_q <= (cnt_q == 6'd6) ? 8'hD5 : 8'h55;
                        end
                    end
                end
                S_BODY: begin
                    if (xfer) begin
                        crc_q <= crc_nxt;
                        if (cnt_q == 6'd59) begin
                            // First FCS byte must include the last body byte's update.
                            cnt_q  <= '0;
                            data_q <= ~crc_nxt[7:0];
                            state  <= S_FCS;
                        end else begin
                            cnt_q  <= cnt_q + 6'd1;
                            data_q <= body_byte(cnt_q + 6'd1);
                        end
                    end
                end
                S_FCS: begin
                    if (xfer) begin
                        if (cnt_q == 6'd3) begin
                            cnt_q   <= '0;
                            data_q  <= 8'h00;
                            vl_q    <= 1'b0;
                            o_sent  <= 1'b1;
                            ifg_cnt <= IFG_W'(IFG_CYCLES - 1);
                            state   <= S_IFG;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                            case (cnt_q[1:0])
                                2'd0:    data_q <= ~crc_q[15:8];
                                2'd1:    data_q <= ~crc_q[23:16];
                                default: data_q <= ~crc_q[31:24];
                            endcase
                        end
                    end
                end
                S_IFG: begin
                    if (ifg_cnt == '0)
                        state <= S_IDLE;
                    else
                        ifg_cnt <= ifg_cnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arp_reply_tx.sv
// Randomized bench for arp_reply_tx: a byte-level frame model built from the
// reply layout is compared against the transmitted stream, timing and pulses.
module tb_arp_reply_tx;
    localparam int IFG = 12;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [47:0] i_self_mac;
    logic [31:0] i_self_ip;
    logic [1:0]  i_pkt_type;
    logic [47:0] i_sha;
    logic [31:0] i_spa;
    logic [31:0] i_tpa;
    logic        o_busy, o_sent, o_dropped;

    arp_reply_tx_if tx_if();

    arp_reply_tx #(.IFG_CYCLES(IFG)) dut (
        .clk(clk), .rst_n(rst_n), .i_self_mac(i_self_mac), .i_self_ip(i_self_ip),
        .i_pkt_type(i_pkt_type), .i_sha(i_sha), .i_spa(i_spa), .i_tpa(i_tpa),
        .tx(tx_if), .o_busy(o_busy), .o_sent(o_sent), .o_dropped(o_dropped)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          last_xfer = 0;
    logic [7:0]  rx_q[$];
    logic [7:0]  exp_q[$];
    int          sent_q[$];
    int          drop_q[$];
    logic        s_vl, s_busy;
    logic [7:0]  s_data;
    logic        hold_pend = 1'b0;
    logic [7:0]  hold_data;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (tick %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    task automatic push_be(input logic [47:0] v, input int n);
        for (int k = n - 1; k >= 0; k--) exp_q.push_back(8'(v >> (8 * k)));
    endtask

    // Reference frame built straight from the reply layout.
    task automatic build_exp(input logic [47:0] sha, input logic [31:0] spa);
        logic [31:0] c;
        exp_q.delete();
        repeat (7) exp_q.push_back(8'h55);
        exp_q.push_back(8'hD5);
        push_be(sha, 6);
        push_be(i_self_mac, 6);
        push_be(48'h0806, 2);
        push_be(48'h0001, 2);
        push_be(48'h0800, 2);
        push_be(48'h06, 1);
        push_be(48'h04, 1);
        push_be(48'h0002, 2);
        push_be(i_self_mac, 6);
        push_be({16'h0, i_self_ip}, 4);
        push_be(sha, 6);
        push_be({16'h0, spa}, 4);
        while (exp_q.size() < 68) exp_q.push_back(8'h00);
        c = 32'hFFFF_FFFF;
        for (int k = 8; k < 68; k++) c = crc_upd(c, exp_q[k]);
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back(8'(c >> (8 * k)));
    endtask

    // One clock: sample outputs at the falling edge, then drive inputs for the next rising edge.
    task automatic tick(input logic [1:0] ptype, input logic rdy);
        @(negedge clk);
        cyc++;
        s_vl = tx_if.o_data_vl;
        s_data = tx_if.o_data;
        s_busy = o_busy;
        if (o_sent) sent_q.push_back(cyc);
        if (o_dropped) drop_q.push_back(cyc);
        if (hold_pend && s_vl) chk("hold_data", s_data, hold_data);
        hold_pend = s_vl && !rdy;
        hold_data = s_data;
        tx_if.i_rdy = rdy;
        if (s_vl && rdy) begin
            rx_q.push_back(s_data);
            last_xfer = cyc;
        end
        i_pkt_type = ptype;
        if (ptype == 2'd0) begin
            i_sha = {16'($urandom), $urandom};
            i_spa = $urandom;
            i_tpa = $urandom;
        end
    endtask

    task automatic do_frame(input logic [47:0] sha, input logic [31:0] spa, input int rdy_pct,
                            input bit hold_last, input int drop_at, output int c0);
        int first_vl, holds;
        logic rdy;
        logic [31:0] r;
        build_exp(sha, spa);
        rx_q.delete(); sent_q.delete(); drop_q.delete();
        i_sha = sha; i_spa = spa; i_tpa = i_self_ip;
        tick(2'd1, 1'b1);
        c0 = cyc;
        first_vl = -1;
        holds = 0;
        for (int k = 0; k < 3000 && sent_q.size() == 0; k++) begin
            rdy = ($urandom_range(99) < rdy_pct);
            if (hold_last && rx_q.size() == 71 && holds < 3) begin
                rdy = 1'b0;
                holds++;
            end
            if (cyc + 1 - c0 == drop_at) begin
                i_sha = {16'($urandom), $urandom};
                i_spa = $urandom;
                i_tpa = i_self_ip;
                tick(2'd1, rdy);
            end else begin
                tick(2'd0, rdy);
            end
            if (first_vl < 0 && s_vl) first_vl = cyc;
        end
        chk("sent_count", sent_q.size(), 1);
        chk("first_vl_tick", first_vl - c0, 1);
        chk("frame_len", rx_q.size(), 72);
        for (int k = 0; k < 72 && k < rx_q.size(); k++) chk($sformatf("byte%0d", k), rx_q[k], exp_q[k]);
        if (rx_q.size() == 72) begin
            r = 32'hFFFF_FFFF;
            for (int k = 8; k < 72; k++) r = crc_upd(r, rx_q[k]);
            chk("crc_residue", r, 32'hDEBB_20E3);
        end
        if (sent_q.size() > 0) begin
            chk("sent_after_last", sent_q[0] - last_xfer, 1);
            if (rdy_pct >= 100) chk("sent_tick", sent_q[0] - c0, 73);
        end
        if (hold_last) chk("last_fcs_held", holds, 3);
    endtask

    task automatic wait_idle();
        int st;
        st = (sent_q.size() > 0) ? sent_q[0] : cyc;
        for (int k = 0; k < 200; k++) begin
            tick(2'd0, 1'b1);
            if (!s_busy) break;
        end
        chk("idle_tick", cyc - st, IFG);
    endtask

    initial begin
        int c0, c1;
        logic seen_vl, seen_busy;
        rst_n = 1'b0;
        tx_if.i_rdy = 1'b0;
        i_pkt_type = 2'd0;
        i_self_mac = 48'h02_00_00_00_00_01;
        i_self_ip  = 32'hC0A8_000A;
        i_sha = '0; i_spa = '0; i_tpa = '0;
        tick(2'd0, 1'b0);
        tick(2'd0, 1'b0);
        chk("rst_vl", tx_if.o_data_vl, 0);
        chk("rst_data", tx_if.o_data, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_sent", o_sent, 0);
        chk("rst_dropped", o_dropped, 0);
        rst_n = 1'b1;
        tick(2'd0, 1'b1);

        do_frame(48'h00_11_22_33_44_55, 32'hC0A8_0001, 100, 0, 0, c0);
        wait_idle();

        // Non-matching TPA, then ARP_RESP/UDP types with a matching TPA: all ignored.
        for (int t = 0; t < 3; t++) begin
            drop_q.delete();
            seen_vl = 1'b0; seen_busy = 1'b0;
            i_sha = 48'h00_11_22_33_44_55;
            i_spa = 32'hC0A8_0001;
            i_tpa = (t == 0) ? 32'hC0A8_000B : i_self_ip;
            tick((t == 0) ? 2'd1 : 2'(t + 1), 1'b1);
            for (int k = 0; k < 100; k++) begin
                tick(2'd0, 1'b1);
                seen_vl |= s_vl;
                seen_busy |= s_busy;
            end
            chk($sformatf("ignored%0d_vl", t), seen_vl, 0);
            chk($sformatf("ignored%0d_busy", t), seen_busy, 0);
            chk($sformatf("ignored%0d_drop", t), drop_q.size(), 0);
        end

        do_frame(48'h00_11_22_33_44_55, 32'hC0A8_0001, 50, 1, 0, c0);
        wait_idle();

        // Request mid-frame and in the last IFG cycle are dropped; at IDLE re-entry accepted.
        do_frame(48'h00_11_22_33_44_55, 32'hC0A8_0001, 100, 0, 30, c0);
        chk("drop_count", drop_q.size(), 1);
        if (drop_q.size() > 0) chk("drop_tick", drop_q[0] - c0, 31);
        while (cyc < c0 + 83) tick(2'd0, 1'b1);
        i_sha = {16'($urandom), $urandom}; i_spa = $urandom; i_tpa = i_self_ip;
        tick(2'd1, 1'b1);
        chk("last_ifg_busy", s_busy, 1);
        do_frame({16'($urandom), $urandom}, $urandom, 100, 0, 0, c1);
        chk("reaccept_tick", c1 - c0, 73 + IFG);
        chk("ifg_drop_count", drop_q.size(), 1);
        if (drop_q.size() > 0) chk("ifg_drop_tick", drop_q[0], c1);
        wait_idle();

        // Reset while body byte 20 is on the bus.
        rx_q.delete(); sent_q.delete();
        i_sha = 48'hA1_B2_C3_D4_E5_F6; i_spa = 32'h0A00_0001; i_tpa = i_self_ip;
        tick(2'd1, 1'b1);
        for (int k = 0; k < 100 && rx_q.size() < 28; k++) tick(2'd0, 1'b1);
        @(posedge clk);
        #2;
        chk("pre_rst_vl", tx_if.o_data_vl, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_vl", tx_if.o_data_vl, 0);
        chk("mid_rst_busy", o_busy, 0);
        tick(2'd0, 1'b1);
        tick(2'd0, 1'b1);
        rst_n = 1'b1;
        for (int k = 0; k < 120; k++) tick(2'd0, 1'b1);
        chk("rst_no_sent", sent_q.size(), 0);
        chk("rst_idle_busy", s_busy, 0);
        do_frame({16'($urandom), $urandom}, $urandom, 70, 0, 0, c0);
        wait_idle();

        for (int n = 0; n < 3; n++) begin
            i_self_mac = {16'($urandom), $urandom};
            i_self_ip  = $urandom;
            do_frame({16'($urandom), $urandom}, $urandom, $urandom_range(100, 30), n[0], 0, c0);
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/arp_reply_tx.md
# arp_reply_tx

Transmit-side ARP responder, downstream of the Ethernet receiver. It consumes the receiver's one-cycle packet-type pulse and the decoded ARP fields. When an ARP request targets our IP, it builds a complete 72-byte ARP reply frame: preamble/SFD, 60-byte minimum payload including padding, and FCS. It streams the frame byte-by-byte to the PHY transmit path under a ready handshake.

## Interface
- IFG_CYCLES, 12, idle clock cycles enforced after the last FCS byte before a new trigger is accepted
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- i_self_mac  in  48  our MAC; sampled at trigger
- i_self_ip  in  32  our IPv4 address; compared and sampled at trigger
- i_pkt_type  in  2  from receiver: NONE=0, ARP_REQ=1, ARP_RESP=2, UDP=3; valid for exactly one cycle per frame
- i_sha  in  48  requester MAC (ARP SHA); valid in the pulse cycle
- i_spa  in  32  requester IP (ARP SPA); valid in the pulse cycle
- i_tpa  in  32  requested IP (ARP TPA); valid in the pulse cycle
- o_data  out  8  transmit byte
- o_data_vl  out  1  o_data valid
- i_rdy  in  1  PHY accepts o_data this cycle
- o_busy  out  1  frame or IFG in progress
- o_sent  out  1  one-cycle pulse, frame fully accepted
- o_dropped  out  1  one-cycle pulse, matching request arrived while busy

## Operation
- Trigger: i_pkt_type==1 && i_tpa==i_self_ip.
  - In IDLE: latch i_sha, i_spa, i_self_mac, i_self_ip, then go to PREAMBLE.
  - Not in IDLE: pulse o_dropped and ignore the request; no queueing.
  - i_pkt_type==1 with i_tpa mismatch, or any other type: ignored, no pulse.
- A byte is transferred when o_data_vl && i_rdy. The byte counter advances only on a transfer.
- States and transitions:
  - IDLE -> PREAMBLE on trigger.
  - PREAMBLE (8 bytes: 0x55 ×7, 0xD5) -> BODY.
  - BODY (60 bytes) -> FCS.
  - FCS (4 bytes) -> IFG.
  - IFG (IFG_CYCLES clock cycles, o_data_vl=0) -> IDLE.
- BODY byte order; multi-byte fields go MSB first:
  - 0–5: dst MAC = latched SHA
  - 6–11: src MAC = self MAC
  - 12–13: 08 06
  - 14–15: HTYPE 00 01
  - 16–17: PTYPE 08 00
  - 18: HLEN 06
  - 19: PLEN 04
  - 20–21: OPER 00 02
  - 22–27: SHA = self MAC
  - 28–31: SPA = self IP
  - 32–37: THA = latched SHA
  - 38–41: TPA = latched SPA
  - 42–59: 0x00 padding
- CRC32 (IEEE, reflected, poly 0xEDB88320):
  - Register is set to 0xFFFFFFFF on entry to PREAMBLE.
  - It updates only on transferred BODY bytes.
  - FCS = ~crc, sent least-significant byte first (crc[7:0] first).
  - The CRC register holds during FCS.
- o_sent pulses in the cycle after the 4th FCS byte transfers, coincident with entry to IFG.
- o_busy = (state != IDLE).
- Latched fields are held constant for the whole frame. Input changes after the trigger have no effect.

## Timing
- Reset values:
  - state IDLE, byte counter 0, IFG counter 0
  - CRC register 0xFFFFFFFF
  - o_data 0x00, o_data_vl 0, o_busy 0, o_sent 0, o_dropped 0
- Trigger is sampled at edge T. o_data_vl=1 with o_data=0x55 from T+1.
- o_data and o_data_vl are functions of registered state and counters only; no combinational path from i_rdy.
- With i_rdy held high, the frame occupies cycles T+1..T+72. o_sent is high at T+73. IDLE is re-entered at T+73+IFG_CYCLES. Trigger-to-trigger minimum is 73+IFG_CYCLES cycles.
- i_rdy low: o_data/o_data_vl hold; counter and CRC do not change. This applies in every state, including the last FCS byte.
- A trigger in the same cycle IDLE is re-entered is accepted. A trigger in the last IFG cycle is dropped.
- Reset asserted mid-frame: immediate return to reset values (o_data_vl falls asynchronously). No o_sent; the partial frame is abandoned.
- o_dropped can pulse in any non-IDLE state and does not disturb the frame in flight.

## Test plan
- Basic reply, i_rdy=1:
  - Stimulus: self MAC 02:00:00:00:00:01, IP 192.168.0.10; request SHA 00:11:22:33:44:55, SPA 192.168.0.1, TPA 192.168.0.10.
  - Required: 72 bytes in order 55×7, D5, 00 11 22 33 44 55 02 00 00 00 00 01 08 06 00 01 08 00 06 04 00 02 …, FCS equal to the reference model.
  - CRC over the 64 bytes after the SFD must leave register residue 0xDEBB20E3.
  - o_sent at T+73.
- TPA mismatch (192.168.0.11): no o_data_vl, o_busy stays 0, no o_dropped.
- Backpressure: i_rdy pseudo-random 50%, including a low on the final FCS byte. The byte sequence and FCS must be identical to test 1; o_sent follows the last transfer by 1 cycle.
- Second matching request at T+30:
  - o_dropped pulses once at T+31.
  - The frame in flight is unchanged.
  - A request at exactly T+73+IFG_CYCLES is accepted.
- i_pkt_type=2 or 3 with a matching TPA: ignored.
- Reset pulse at body byte 20: o_data_vl 0 immediately, o_busy 0, no o_sent. A subsequent request produces a correct full frame.
